weight_fetch_ctrl: RTL and testbench

WEIGHT_FETCH_CTRL -- requirements
Module: weight_fetch_ctrl

---
 rtl/weight_ctrl_pkg.sv | 22 ++
 rtl/weight_skid_fifo.sv | 70 +++++++
 rtl/weight_fetch_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_weight_fetch_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/weight_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : weight_ctrl_pkg
// Brief    : Shared state encoding and default sizing for the weight fetch
//            controller and its output FIFO.
// Revision : 1.0 - initial release
// ============================================================================
package weight_ctrl_pkg;

  localparam int unsigned c_DEF_DEPTH = 28;
  localparam int unsigned c_DEF_WIDTH = 16;
  localparam int unsigned c_DEF_AW    = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FETCH = 2'd2,
    ST_DRAIN = 2'd3
  } wfc_state_e;

endpackage
`default_nettype wire

// File: rtl/weight_skid_fifo.sv
`default_nettype none
// ============================================================================
// Module   : weight_skid_fifo
// Brief    : Two-entry FIFO holding BRAM read data together with the address
//            it was read from. Head is presented combinationally and stays
//            put until popped.
// Revision : 1.0 - initial release
// ============================================================================
module weight_skid_fifo
  import weight_ctrl_pkg::*;
#(
  parameter int WIDTH = c_DEF_WIDTH,
  parameter int AW    = c_DEF_AW
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic [AW-1:0]    idx_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic [AW-1:0]    idx_o,
  output logic [1:0]       count_o
);

  logic [WIDTH-1:0] data_q [2];
  logic [AW-1:0]    idx_q  [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;

  logic pop_ok;
  logic push_ok;

  // A pop only counts when something is there; a push into a full FIFO is
  // accepted only when the head leaves in the same cycle.
  assign pop_ok  = pop_i && (count_q != 2'd0);
  assign push_ok = push_i && ((count_q != 2'd2) || pop_ok);

  // Storage, pointers and occupancy
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q[0] <= '0;
      data_q[1] <= '0;
      idx_q[0]  <= '0;
      idx_q[1]  <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
    end else begin
      if (push_ok) begin
        data_q[wr_ptr_q] <= data_i;
        idx_q[wr_ptr_q]  <= idx_i;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop_ok) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, push_ok} - {1'b0, pop_ok};
    end
  end

  assign valid_o = (count_q != 2'd0);
  assign data_o  = data_q[rd_ptr_q];
  assign idx_o   = idx_q[rd_ptr_q];
  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/weight_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : weight_fetch_ctrl
// Brief    : Loads weight words from a host stream into a single-port BRAM and
//            later streams them out in address order to the MAC, using a
//            two-credit read scheme so the output FIFO never overflows.
// Revision : 1.0 - initial release
// ============================================================================
module weight_fetch_ctrl
  import weight_ctrl_pkg::*;
#(
  parameter int DEPTH = c_DEF_DEPTH,
  parameter int WIDTH = c_DEF_WIDTH,
  parameter int AW    = c_DEF_AW
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  output logic             busy_o,
  output logic             done_o,
  input  logic             load_valid_i,
  output logic             load_ready_o,
  input  logic [WIDTH-1:0] load_data_i,
  output logic             load_done_o,
  output logic             w_valid_o,
  input  logic             w_ready_i,
  output logic [WIDTH-1:0] w_data_o,
  output logic [AW-1:0]    w_idx_o,
  output logic [AW-1:0]    bram_addr_o,
  output logic [WIDTH-1:0] bram_di_o,
  output logic             bram_en_o,
  output logic             bram_we_o,
  input  logic [WIDTH-1:0] bram_do_i
);

  localparam logic [AW-1:0] c_LAST = AW'(DEPTH - 1);

  wfc_state_e       state_q;
  logic [1:0]       sync_q;
  logic [AW-1:0]    cnt_q;
  logic             last_q;
  logic             done_q;
  logic             load_ready_q;
  logic             load_done_q;
  logic             bram_en_q;
  logic             bram_we_q;
  logic [AW-1:0]    bram_addr_q;
  logic [WIDTH-1:0] bram_di_q;

  logic             run;
  logic             rd_inflight;
  logic             w_pop;
  logic             fifo_valid;
  logic [WIDTH-1:0] fifo_data;
  logic [AW-1:0]    fifo_idx;
  logic [1:0]       fifo_cnt;
  logic [2:0]       occ_d;
  logic             issue_ok;

  // Address counter that sticks at the last word instead of wrapping
  function automatic logic [AW-1:0] sat_inc(input logic [AW-1:0] a);
    return (a == c_LAST) ? a : a + AW'(1);
  endfunction

  // Reset release is re-timed through two flops; the FSM stays put until
  // the second one is set, so a late-arriving deassertion cannot split state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], 1'b1};
    end
  end

  assign run         = sync_q[1];
  assign rd_inflight = bram_en_q && !bram_we_q;
  assign w_pop       = fifo_valid && w_ready_i;

  // Occupancy the FIFO will have after this edge: the outstanding read lands
  // and the head may leave. A new read is issued only if it still fits.
  assign occ_d    = {1'b0, fifo_cnt} + {2'b00, rd_inflight} - {2'b00, w_pop};
  assign issue_ok = (occ_d < 3'd2);

  // Control FSM: host load sequencing, credit-limited reads and completion
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      last_q       <= 1'b0;
      done_q       <= 1'b0;
      load_ready_q <= 1'b0;
      load_done_q  <= 1'b0;
      bram_en_q    <= 1'b0;
      bram_we_q    <= 1'b0;
      bram_addr_q  <= '0;
      bram_di_q    <= '0;
    end else begin
      done_q      <= 1'b0;
      load_done_q <= 1'b0;
      bram_en_q   <= 1'b0;
      bram_we_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (run) begin
            if (start_i) begin
              state_q <= ST_FETCH;
              cnt_q   <= '0;
              last_q  <= 1'b0;
            end else if (load_valid_i) begin
              state_q      <= ST_LOAD;
              cnt_q        <= '0;
              load_ready_q <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (!load_ready_q) begin
            // Final write is on the BRAM port this cycle; wrap up after it.
            state_q     <= ST_IDLE;
            load_done_q <= 1'b1;
          end else if (load_valid_i) begin
            bram_en_q   <= 1'b1;
            bram_we_q   <= 1'b1;
            bram_addr_q <= cnt_q;
            bram_di_q   <= load_data_i;
            cnt_q       <= sat_inc(cnt_q);
            if (cnt_q == c_LAST) begin
              load_ready_q <= 1'b0;
            end
          end
        end
        ST_FETCH: begin
          if (last_q) begin
            state_q <= ST_DRAIN;
          end else if (issue_ok) begin
            bram_en_q   <= 1'b1;
            bram_addr_q <= cnt_q;
            cnt_q       <= sat_inc(cnt_q);
            last_q      <= (cnt_q == c_LAST);
          end
        end
        ST_DRAIN: begin
          if (w_pop && (fifo_idx == c_LAST)) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  weight_skid_fifo #(
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (rd_inflight),
    .data_i  (bram_do_i),
    .idx_i   (bram_addr_q),
    .pop_i   (w_pop),
    .valid_o (fifo_valid),
    .data_o  (fifo_data),
    .idx_o   (fifo_idx),
    .count_o (fifo_cnt)
  );

  assign busy_o       = (state_q != ST_IDLE);
  assign done_o       = done_q;
  assign load_ready_o = load_ready_q;
  assign load_done_o  = load_done_q;
  assign w_valid_o    = fifo_valid;
  assign w_data_o     = fifo_data;
  assign w_idx_o      = fifo_idx;
  assign bram_addr_o  = bram_addr_q;
  assign bram_di_o    = bram_di_q;
  assign bram_en_o    = bram_en_q;
  assign bram_we_o    = bram_we_q;

endmodule
`default_nettype wire

// File: tb/tb_weight_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_weight_fetch_ctrl
// Brief    : Scoreboard bench for weight_fetch_ctrl with a behavioural BRAM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_weight_fetch_ctrl;

  localparam int DEPTH = 28;
  localparam int WIDTH = 16;
  localparam int AW    = 5;

  typedef logic [AW+WIDTH-1:0] ent_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             busy;
  logic             done;
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;
  logic             load_done;
  logic             w_valid;
  logic             w_ready;
  logic [WIDTH-1:0] w_data;
  logic [AW-1:0]    w_idx;
  logic [AW-1:0]    bram_addr;
  logic [WIDTH-1:0] bram_di;
  logic             bram_en;
  logic             bram_we;
  logic [WIDTH-1:0] bram_do;

  logic [WIDTH-1:0] bram_mem [32];
  logic [WIDTH-1:0] exp_mem  [DEPTH];
  ent_t             sb_q[$];
  ent_t             wr_q[$];

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  int  occ, done_cnt, ld_done_cnt, done_cyc, start_cyc;
  int  first_valid_cyc, first_pop_cyc, last_pop_cyc, first_wr_cyc, last_wr_cyc;
  bit  rd_prev, pop_prev, stall_prev, done_exp, seen_valid, in_fetch;
  logic [WIDTH-1:0] held_data;
  logic [AW-1:0]    held_idx;

  weight_fetch_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start),
    .busy_o       (busy),
    .done_o       (done),
    .load_valid_i (load_valid),
    .load_ready_o (load_ready),
    .load_data_i  (load_data),
    .load_done_o  (load_done),
    .w_valid_o    (w_valid),
    .w_ready_i    (w_ready),
    .w_data_o     (w_data),
    .w_idx_o      (w_idx),
    .bram_addr_o  (bram_addr),
    .bram_di_o    (bram_di),
    .bram_en_o    (bram_en),
    .bram_we_o    (bram_we),
    .bram_do_i    (bram_do)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Single-port BRAM: access on the falling edge, DO held while EN is low
  always @(negedge clk) begin
    if (bram_en) begin
      if (bram_we) bram_mem[bram_addr] <= bram_di;
      else         bram_do <= bram_mem[bram_addr];
    end
  end

  // Monitor: FIFO occupancy model, scoreboards, hold-while-stalled, DONE timing
  always @(negedge clk) begin
    bit rd_now, pop_now;
    ent_t e;
    if (!rst_n) begin
      occ = 0; rd_prev = 0; pop_prev = 0; stall_prev = 0; done_exp = 0;
    end else begin
      rd_now  = bram_en && !bram_we;
      pop_now = w_valid && w_ready;
      occ     = occ + int'(rd_prev) - int'(pop_prev);
      check_val("w_valid_vs_occ", w_valid, occ != 0);
      if (rd_now) check_val("credit_rule", occ < 2, 1'b1);
      check_val("done_timing", done, done_exp);
      if (stall_prev) begin
        check_val("hold_valid", w_valid, 1'b1);
        check_val("hold_data", w_data, held_data);
        check_val("hold_idx", w_idx, held_idx);
      end
      if (in_fetch) begin
        check_val("we_in_fetch", bram_we, 1'b0);
        check_val("ldrdy_in_fetch", load_ready, 1'b0);
      end
      if (w_valid && !seen_valid) begin
        seen_valid = 1; first_valid_cyc = cyc;
      end
      if (pop_now) begin
        check_val("sb_nonempty", sb_q.size() > 0, 1'b1);
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          check_val("w_idx", w_idx, e[AW+WIDTH-1:WIDTH]);
          check_val("w_data", w_data, e[WIDTH-1:0]);
        end
        if (w_idx == 0) first_pop_cyc = cyc;
        if (w_idx == AW'(DEPTH-1)) last_pop_cyc = cyc;
      end
      if (bram_en && bram_we) begin
        check_val("wr_nonempty", wr_q.size() > 0, 1'b1);
        if (wr_q.size() > 0) begin
          e = wr_q.pop_front();
          check_val("wr_addr", bram_addr, e[AW+WIDTH-1:WIDTH]);
          check_val("wr_data", bram_di, e[WIDTH-1:0]);
        end
        if (bram_addr == 0) first_wr_cyc = cyc;
        last_wr_cyc = cyc;
      end
      if (load_done) begin
        ld_done_cnt++;
        check_val("ld_done_lat", cyc - last_wr_cyc, 1);
      end
      if (done) begin
        done_cnt++; done_cyc = cyc;
      end
      done_exp   = pop_now && (w_idx == AW'(DEPTH-1));
      stall_prev = w_valid && !w_ready;
      held_data  = w_data;
      held_idx   = w_idx;
      rd_prev    = rd_now;
      pop_prev   = pop_now;
    end
  end

  task automatic load_all(input logic [WIDTH-1:0] base, input int step, input bit gaps);
    int i = 0;
    int guard = 0;
    bit acc;
    ld_done_cnt = 0; first_wr_cyc = -1;
    @(posedge clk); #1;
    load_valid = 1'b1;
    load_data  = base;
    while (i < DEPTH && guard < 500) begin
      @(negedge clk);
      acc = load_valid && load_ready;
      if (acc) begin
        wr_q.push_back({AW'(i), load_data});
        exp_mem[i] = load_data;
      end
      @(posedge clk); #1;
      guard++;
      if (acc) begin
        i++;
        load_data = base + WIDTH'(i * step);
      end
      load_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
    load_valid = 1'b0;
    check_val("load_accepted", i, DEPTH);
    repeat (6) @(posedge clk);
    #1;
    check_val("ld_done_cnt", ld_done_cnt, 1);
    check_val("wr_q_left", wr_q.size(), 0);
    check_val("busy_after_load", busy, 1'b0);
    if (!gaps) check_val("ld_consecutive", last_wr_cyc - first_wr_cyc, DEPTH - 1);
  endtask

  // mode: 0 = ready held high, 1 = ready toggles, 2 = random ready
  task automatic run_fetch(input int mode, input bit noise, input int abort_idx);
    int t = 0;
    for (int i = 0; i < DEPTH; i++) sb_q.push_back({AW'(i), exp_mem[i]});
    done_cnt = 0; seen_valid = 0; first_pop_cyc = -1; last_pop_cyc = -1; done_cyc = -1;
    @(posedge clk); #1;
    w_ready = 1'b1;
    start   = 1'b1;
    if (noise) load_valid = 1'b1;
    @(posedge clk); #1;
    start_cyc = cyc;
    start     = 1'b0;
    in_fetch  = 1;
    while (done_cnt == 0 && t < 400) begin
      @(posedge clk); #1;
      t++;
      case (mode)
        0:       w_ready = 1'b1;
        1:       w_ready = ~w_ready;
        default: w_ready = ($urandom_range(0, 1) == 1);
      endcase
      if (noise) begin
        start      = ((t % 5) == 2) && busy;
        load_valid = (t < 6);
      end
      if (abort_idx >= 0 && w_valid && (w_idx == AW'(abort_idx))) begin
        rst_n = 1'b0;
        #1;
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_done", done, 1'b0);
        check_val("rst_w_valid", w_valid, 1'b0);
        check_val("rst_w_data", w_data, 0);
        check_val("rst_w_idx", w_idx, 0);
        check_val("rst_bram_en", bram_en, 1'b0);
        check_val("rst_bram_addr", bram_addr, 0);
        check_val("rst_bram_di", bram_di, 0);
        sb_q.delete();
        in_fetch = 0;
        repeat (3) @(posedge clk);
        check_val("rst_no_done", done_cnt, 0);
        return;
      end
    end
    start = 1'b0; load_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    in_fetch = 0; w_ready = 1'b1;
    check_val("done_count", done_cnt, 1);
    check_val("sb_left", sb_q.size(), 0);
    check_val("first_valid_lat", first_valid_cyc - start_cyc, 2);
    check_val("done_after_last_pop", done_cyc - last_pop_cyc, 1);
    check_val("busy_end", busy, 1'b0);
    if (mode == 0) check_val("pop_span", last_pop_cyc - first_pop_cyc, DEPTH - 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) bram_mem[i] = '0;
    bram_do = '0; in_fetch = 0;
    rst_n = 1'b0; start = 1'b0; load_valid = 1'b0; load_data = '0; w_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_busy", busy, 1'b0);
    check_val("reset_done", done, 1'b0);
    check_val("reset_load_ready", load_ready, 1'b0);
    check_val("reset_load_done", load_done, 1'b0);
    check_val("reset_w_valid", w_valid, 1'b0);
    check_val("reset_bram_en", bram_en, 1'b0);
    check_val("reset_bram_we", bram_we, 1'b0);
    check_val("reset_w_data", w_data, 0);
    check_val("reset_w_idx", w_idx, 0);
    check_val("reset_bram_addr", bram_addr, 0);
    check_val("reset_bram_di", bram_di, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);

    load_all(16'h0001, 1, 1'b0);
    run_fetch(0, 1'b0, -1);
    run_fetch(1, 1'b0, -1);

    load_all(16'hA5A0, 7, 1'b1);
    run_fetch(1, 1'b0, -1);
    run_fetch(0, 1'b1, -1);

    run_fetch(0, 1'b0, 10);
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    check_val("rst_sync_hold", busy, 1'b0);
    start = 1'b0;
    repeat (3) @(posedge clk);
    run_fetch(0, 1'b0, -1);
    run_fetch(2, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
